// File: rtl/riscv_pkg.sv
// ============================================================================
// Module   : riscv_pkg
// Brief    : Shared RV32 constants and the IF/ID pipeline register type.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] instr;
    } if_id_t;

endpackage

`default_nettype wire

// File: rtl/fetch_stage_if.sv
// ============================================================================
// Module   : fetch_stage_if
// Brief    : Control, instruction-memory and IF/ID signals of the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_stage_if;

    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_data_i;
    logic        if_id_valid_o;
    logic [31:0] if_id_pc_o;
    logic [31:0] if_id_pc4_o;
    logic [31:0] if_id_instr_o;
    logic        misalign_o;
    logic [31:0] misalign_addr_o;

    // Fetch-stage side.
    modport master (
        input  stall_i, redirect_i, redirect_pc_i, imem_data_i,
        output imem_addr_o, if_id_valid_o, if_id_pc_o, if_id_pc4_o,
               if_id_instr_o, misalign_o, misalign_addr_o
    );

    // Hazard logic / instruction memory / decode side.
    modport slave (
        output stall_i, redirect_i, redirect_pc_i, imem_data_i,
        input  imem_addr_o, if_id_valid_o, if_id_pc_o, if_id_pc4_o,
               if_id_instr_o, misalign_o, misalign_addr_o
    );

endinterface

`default_nettype wire

// File: rtl/fetch_pc_gen.sv
// ============================================================================
// Module   : fetch_pc_gen
// Brief    : PC register, next-PC select and redirect alignment check.
//            Macro FETCH_MISALIGN_TRAP_EN enables the sticky misalign capture.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_pc_gen
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        stall,
    input  wire logic        redirect,
    input  wire logic [31:0] redirect_pc,
    output logic      [31:0] pc,
    output logic      [31:0] pc4,
    output logic             misalign,
    output logic      [31:0] misalign_addr
);

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    logic [31:0] next_pc;

    assign pc4 = pc + PC_STEP;

    always_comb begin
        next_pc = pc;
        if (redirect) begin
            next_pc = {redirect_pc[31:2], 2'b00};
        end else if (!stall) begin
            next_pc = pc4;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC_ALIGNED;
        end else begin
            pc <= next_pc;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign_q;
    logic [31:0] misalign_addr_q;

    // Only the first offending target is kept; the flag stays up until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign_q      <= 1'b0;
            misalign_addr_q <= 32'h0000_0000;
        end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
            misalign_q <= 1'b1;
            if (!misalign_q) begin
                misalign_addr_q <= redirect_pc;
            end
        end
    end

    assign misalign      = misalign_q;
    assign misalign_addr = misalign_addr_q;
`else
    logic unused_low_bits;

    assign unused_low_bits = ^redirect_pc[1:0];
    assign misalign        = 1'b0;
    assign misalign_addr   = 32'h0000_0000;
`endif

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module   : fetch_stage
// Brief    : Instruction fetch: PC generation plus the IF/ID pipeline register.
//            Macro FETCH_MISALIGN_TRAP_EN enables misaligned-redirect capture.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = INSTR_NOP
) (
    input  wire logic    clk,
    input  wire logic    reset,
    fetch_stage_if.master bus
);

    logic [31:0] pc;
    logic [31:0] pc4;
    if_id_t      if_id;

    fetch_pc_gen #(
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk           (clk),
        .reset         (reset),
        .stall         (bus.stall_i),
        .redirect      (bus.redirect_i),
        .redirect_pc   (bus.redirect_pc_i),
        .pc            (pc),
        .pc4           (pc4),
        .misalign      (bus.misalign_o),
        .misalign_addr (bus.misalign_addr_o)
    );

    assign bus.imem_addr_o = pc;

    // A redirect squashes the word in flight; pc/pc4 are left as they were.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_id <= '{valid: 1'b0, pc: 32'h0, pc4: 32'h0, instr: NOP_INSTR};
        end else if (bus.redirect_i) begin
            if_id.valid <= 1'b0;
            if_id.instr <= NOP_INSTR;
        end else if (!bus.stall_i) begin
            if_id <= '{valid: 1'b1, pc: pc, pc4: pc4, instr: bus.imem_data_i};
        end
    end

    assign bus.if_id_valid_o = if_id.valid;
    assign bus.if_id_pc_o    = if_id.pc;
    assign bus.if_id_pc4_o   = if_id.pc4;
    assign bus.if_id_instr_o = if_id.instr;

endmodule

`default_nettype wire
